// File: rtl/tx_packet_pkg.sv
// Constants and types shared by the response transmitter and its receiver.
// Holds the packet framing bytes, default sizing and the serializer state encoding.
package tx_packet_pkg;

  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam int DEF_PKT_BYTES = 8;
  localparam int DEF_BIT_CLKS  = 2414;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // XOR of the address byte and the four data bytes.
  function automatic logic [7:0] checksum(input logic [6:0] addr, input logic [31:0] data);
    return {1'b0, addr} ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// Handshake: start is honoured only in IDLE; more, sampled at the end of a stop
// bit, chains straight into the next start bit; byte_done pulses on that cycle.
module uart_tx_byte
  import tx_packet_pkg::*;
#(
  parameter int BIT_CLKS = DEF_BIT_CLKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       more,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done,
  output tx_state_e  state
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CLKS - 1);

  tx_state_e     state_next;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic          bit_end;
  logic          tx_d;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      tx       <= tx_d;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = bit_end ? '0 : baud_cnt + 1'b1;
    bit_next   = bit_idx;
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (start) state_next = START;
      end
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end) begin
          bit_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: if (bit_end) state_next = more ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is computed from the next state so the line is a flop with no extra lag.
  always_comb begin
    byte_done = (state == STOP) && bit_end;
    case (state_next)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data[bit_next];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/tx_packet.sv
// Response packet transmitter: STX, addr, 4 data bytes LSB first, XOR checksum, ETX.
// Latches addr/ram_data on an accepted tx_start and sequences bytes into uart_tx_byte.
module tx_packet
  import tx_packet_pkg::*;
#(
  parameter int BIT_CLKS  = DEF_BIT_CLKS,
  parameter int PKT_BYTES = DEF_PKT_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [6:0]  addr,
  input  logic [31:0] ram_data,
  output logic        tx_out,
  output logic        busy,
  output logic        done
);

  localparam int BW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(PKT_BYTES - 1);

  logic [6:0]    addr_q;
  logic [31:0]   data_q;
  logic [BW-1:0] byte_idx;
  logic [7:0]    cur_byte;
  logic          accept;
  logic          last_byte;
  logic          byte_done;
  tx_state_e     ser_state;

  assign accept    = tx_start && !busy && (ser_state == IDLE);
  assign last_byte = (byte_idx == BYTE_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        data_q <= ram_data;
        busy   <= 1'b1;
      end
      if (byte_done) begin
        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        if (last_byte) busy <= 1'b0;
      end
      done <= byte_done && last_byte;
    end
  end

  always_comb begin
    cur_byte = ETX;
    if (int'(byte_idx) == 0)                  cur_byte = STX;
    else if (int'(byte_idx) == 1)             cur_byte = {1'b0, addr_q};
    else if (int'(byte_idx) == 2)             cur_byte = data_q[7:0];
    else if (int'(byte_idx) == 3)             cur_byte = data_q[15:8];
    else if (int'(byte_idx) == 4)             cur_byte = data_q[23:16];
    else if (int'(byte_idx) == 5)             cur_byte = data_q[31:24];
    else if (int'(byte_idx) == PKT_BYTES - 2) cur_byte = checksum(addr_q, data_q);
  end

  uart_tx_byte #(
    .BIT_CLKS(BIT_CLKS)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .more     (!last_byte),
    .data     (cur_byte),
    .tx       (tx_out),
    .byte_done(byte_done),
    .state    (ser_state)
  );

endmodule

// File: tb/tb_tx_packet.sv
// Bench for tx_packet with 16-cycle bits: table of packets checked bit-cell by
// bit-cell, plus hand-written reset-abort and back-to-back sequences.
module tb_tx_packet;

  localparam int BC = 16;
  localparam int PB = 8;
  localparam int M_NORMAL = 0;
  localparam int M_IGNORE = 1;
  localparam int M_CHANGE = 2;
  localparam int M_B2B    = 3;
  localparam int ABORT_S  = (4 * 10 + 1 + 3) * BC + 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_start = 1'b0;
  logic [6:0]  addr = '0;
  logic [31:0] ram_data = '0;
  logic        tx_out;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int idle_err = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [63:0] exp;
    int          mode;
  } vec_t;

  vec_t vecs[6];

  tx_packet #(.BIT_CLKS(BC), .PKT_BYTES(PB)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .addr    (addr),
    .ram_data(ram_data),
    .tx_out  (tx_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rst && busy === 1'b0 && tx_out !== 1'b1) idle_err++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge, pulses tx_start and checks every cycle of the packet;
  // returns at the negedge of the done cycle.
  task automatic run_packet(input vec_t v, input string tag);
    logic [7:0] e;
    logic [7:0] obs;
    logic       exp_bit;
    int         frame_err;
    int         busy_err;
    int         s;
    frame_err = 0;
    busy_err  = 0;
    addr      = v.addr;
    ram_data  = v.data;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start  = 1'b0;
    for (int b = 0; b < PB; b++) begin
      e   = v.exp[63 - 8 * b -: 8];
      obs = '0;
      for (int j = 0; j < 10; j++) begin
        if (j == 0)      exp_bit = 1'b0;
        else if (j == 9) exp_bit = 1'b1;
        else             exp_bit = e[j - 1];
        for (int c = 0; c < BC; c++) begin
          s = (b * 10 + j) * BC + c;
          if (v.mode == M_IGNORE && (s == 100 || s == 600)) begin
            tx_start = 1'b1;
            addr     = 7'h7F;
            ram_data = $urandom;
          end else if (v.mode == M_IGNORE && (s == 101 || s == 601)) begin
            tx_start = 1'b0;
          end
          if (v.mode == M_CHANGE && s == 0) ram_data = 32'h0;
          if (tx_out !== exp_bit) frame_err++;
          if (busy !== 1'b1 || done !== 1'b0) busy_err++;
          if (c == BC / 2 && j >= 1 && j <= 8) obs[j - 1] = tx_out;
          @(negedge clk);
        end
      end
      check($sformatf("%s byte%0d", tag, b), {56'h0, obs}, {56'h0, e});
    end
    check({tag, " bit_cells"}, frame_err, 0);
    check({tag, " busy_held"}, busy_err, 0);
    check({tag, " done_pulse"}, {63'h0, done}, 64'h1);
    check({tag, " busy_fell"}, {63'h0, busy}, 64'h0);
    check({tag, " line_idle"}, {63'h0, tx_out}, 64'h1);
  endtask

  task automatic idle_gap(input string tag);
    @(negedge clk);
    check({tag, " done_one_cycle"}, {63'h0, done}, 64'h0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int snap;
    // Checksums: 05^EF^BE^AD^DE = 27, 12^67^45^23^01 = 12, 7F^FF^FF^FF^FF = 7F.
    vecs[0] = '{7'h05, 32'hDEADBEEF, 64'h02_05_EF_BE_AD_DE_27_03, M_NORMAL};
    vecs[1] = '{7'h05, 32'hDEADBEEF, 64'h02_05_EF_BE_AD_DE_27_03, M_IGNORE};
    vecs[2] = '{7'h05, 32'hDEADBEEF, 64'h02_05_EF_BE_AD_DE_27_03, M_CHANGE};
    vecs[3] = '{7'h12, 32'h01234567, 64'h02_12_67_45_23_01_12_03, M_NORMAL};
    vecs[4] = '{7'h00, 32'h00000000, 64'h02_00_00_00_00_00_00_03, M_B2B};
    vecs[5] = '{7'h7F, 32'hFFFFFFFF, 64'h02_7F_FF_FF_FF_FF_7F_03, M_NORMAL};

    repeat (3) @(negedge clk);
    check("reset tx_out", {63'h0, tx_out}, 64'h1);
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset done", {63'h0, done}, 64'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_packet(vecs[i], $sformatf("pkt%0d", i));
      if (!(i < 5 && vecs[i + 1].mode == M_B2B)) idle_gap($sformatf("pkt%0d", i));
    end
    check("done count after table", done_cnt, 6);

    // Abort mid-packet at bit 3 of byte 4.
    addr     = 7'h05;
    ram_data = 32'hDEADBEEF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (ABORT_S) @(negedge clk);
    check("abort busy before", {63'h0, busy}, 64'h1);
    snap = done_cnt;
    rst  = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    check("abort tx_out", {63'h0, tx_out}, 64'h1);
    check("abort busy", {63'h0, busy}, 64'h0);
    check("abort done", {63'h0, done}, 64'h0);
    repeat (PB * 10 * BC) @(negedge clk);
    check("abort no done", done_cnt, snap);
    run_packet(vecs[0], "post_abort");
    idle_gap("post_abort");

    check("done count total", done_cnt, 7);
    check("idle line high", idle_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
